// File: rtl/axis_conv_out_serializer.sv
// Serializes one wide convolution-engine result beat into CORES/CORES_PER_BEAT
// narrower AXI-Stream beats, reordering words from unit-half to core-major layout.
module axis_conv_out_serializer #(
    parameter int CORES          = 32,
    parameter int UNITS          = 8,
    parameter int WORD_WIDTH     = 25,
    parameter int CORES_PER_BEAT = 4,
    parameter int TUSER_WIDTH    = 8
) (
    input  logic                                       aclk,
    input  logic                                       areset,
    input  logic                                       s_axis_tvalid,
    output logic                                       s_axis_tready,
    input  logic [WORD_WIDTH*CORES*UNITS-1:0]          s_axis_tdata,
    input  logic [TUSER_WIDTH-1:0]                     s_axis_tuser,
    input  logic                                       s_axis_tlast,
    output logic                                       m_axis_tvalid,
    input  logic                                       m_axis_tready,
    output logic [WORD_WIDTH*UNITS*CORES_PER_BEAT-1:0] m_axis_tdata,
    output logic [TUSER_WIDTH-1:0]                     m_axis_tuser,
    output logic                                       m_axis_tlast
);

    localparam int BEATS      = CORES / CORES_PER_BEAT;
    localparam int BITS_BEATS = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_BITS  = WORD_WIDTH * UNITS * CORES_PER_BEAT;
    localparam int HALF_UNITS = UNITS / 2;
    localparam logic [BITS_BEATS-1:0] LAST_CNT = BITS_BEATS'(BEATS - 1);

    // The hold-valid flag doubles as the state: EMPTY or serving slices.
    typedef enum logic {
        EMPTY = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t                               state_q, state_d;
    logic [BITS_BEATS-1:0]                cnt_q, cnt_d;
    logic [BEATS-1:0][BEAT_BITS-1:0]      data_q, data_d;
    logic [TUSER_WIDTH-1:0]               tuser_q, tuser_d;
    logic                                 tlast_q, tlast_d;

    logic [CORES-1:0][UNITS-1:0][WORD_WIDTH-1:0] reordered;
    logic                                        in_fire;
    logic                                        out_fire;
    logic                                        on_last;

    // Pure wiring: unit u of core c lives in half h = u / (UNITS/2) of the input.
    for (genvar c = 0; c < CORES; c++) begin : g_core
        for (genvar u = 0; u < UNITS; u++) begin : g_unit
            localparam int H = u / HALF_UNITS;
            localparam int K = H * (CORES * HALF_UNITS) + c * HALF_UNITS + (u % HALF_UNITS);
            assign reordered[c][u] = s_axis_tdata[K*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    assign on_last       = (cnt_q == LAST_CNT);
    assign m_axis_tvalid = (state_q == SERVE);
    assign m_axis_tdata  = data_q[cnt_q];
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q & on_last;

    assign s_axis_tready = !areset && ((state_q == EMPTY) || (m_axis_tready && on_last));
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign out_fire      = m_axis_tvalid && m_axis_tready;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        tuser_d = tuser_q;
        tlast_d = tlast_q;

        if (out_fire) begin
            if (on_last) begin
                state_d = EMPTY;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + BITS_BEATS'(1);
            end
        end

        // A new beat on the final slice handshake overrides the drain, so no bubble.
        if (in_fire) begin
            state_d = SERVE;
            cnt_d   = '0;
            data_d  = reordered;
            tuser_d = s_axis_tuser;
            tlast_d = s_axis_tlast;
        end
    end

    // NOTE: the wide hold register is reset too, so every m_* output reads zero during reset.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            data_q  <= '0;
            tuser_q <= '0;
            tlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            tuser_q <= tuser_d;
            tlast_q <= tlast_d;
        end
    end

endmodule

// File: doc/axis_conv_out_serializer.md
Name: axis_conv_out_serializer

Overview:
- Sits directly downstream of the convolution engine's AXI-Stream output.
- Accepts one wide beat holding WORD_WIDTH-bit results for all CORES x UNITS, which arrives in the engine's two unit-half layout.
- Reorders the words to core-major and emits the beat as CORES/CORES_PER_BEAT narrower beats, so the activation/requant path sees a smaller bus.
- Carries tuser on every output beat and tlast on the final beat only.

Parameters:
- CORES, 32, number of cores in the input beat.
- UNITS, 8, units per core; must be even.
- WORD_WIDTH, 25, bits per result word.
- CORES_PER_BEAT, 4, cores per output beat; must divide CORES.
- TUSER_WIDTH, 8, sideband width, passed through unchanged.
- Derived: BEATS = CORES/CORES_PER_BEAT; BITS_BEATS = max(1, clog2(BEATS)).

Ports:
- aclk  in  1  clock; all logic rising-edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high together with tvalid.
- s_axis_tdata  in  WORD_WIDTH*CORES*UNITS  engine results, unit-half layout.
- s_axis_tuser  in  TUSER_WIDTH  sideband.
- s_axis_tlast  in  1  end of packet.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  WORD_WIDTH*UNITS*CORES_PER_BEAT  core-major slice.
- m_axis_tuser  out  TUSER_WIDTH  held copy of s_axis_tuser.
- m_axis_tlast  out  1  high only on the last slice of an input beat that had tlast=1.

Behaviour:
- Input layout: word k sits at s_axis_tdata[k*WORD_WIDTH +: WORD_WIDTH].
  - Indexing is k = h*(CORES*UNITS/2) + c*(UNITS/2) + uu, with unit u = h*(UNITS/2) + uu, h in {0,1}.
- Output layout: on beat b (0..BEATS-1), output word j = cl*UNITS + u carries core c = b*CORES_PER_BEAT + cl, unit u.
- Storage: hold register (data, tuser, tlast), hold_valid flag, beat counter cnt (BITS_BEATS bits).
- States are encoded by hold_valid:
  - EMPTY (hold_valid=0).
  - SERVE (hold_valid=1, counter selects the slice).
- m_axis_tvalid = hold_valid. m_axis_tdata is the combinational slice of the hold register selected by cnt. m_axis_tuser = held tuser. m_axis_tlast = held tlast AND (cnt == BEATS-1).
- s_axis_tready = !areset AND (!hold_valid OR (m_axis_tready AND cnt == BEATS-1)).
- On input accept: load the hold register, set hold_valid=1, cnt=0. First output beat is valid the next cycle (latency 1).
- On output accept (m_axis_tvalid AND m_axis_tready):
  - cnt < BEATS-1: cnt increments.
  - cnt == BEATS-1 with no simultaneous input: hold_valid clears and cnt returns to 0.
  - cnt == BEATS-1 with a simultaneous input accept: the hold register reloads and cnt=0. No bubble, so sustained throughput is exactly BEATS output beats per input beat.
- Backpressure: while m_axis_tready=0, hold register, cnt and all m_* outputs stay stable (AXIS rule: tvalid never drops without a handshake).
- BEATS=1: the block acts as a single-stage register slice with reorder; it accepts every cycle when downstream is ready.
- Reset (asynchronous, any time, including mid-serialization):
  - hold_valid=0, cnt=0, hold data/tuser/tlast=0.
  - Therefore m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, and s_axis_tready=0 while areset is high.
  - A partially serialized beat is discarded.
- No arithmetic: words are moved, never modified. Widths must be exact, with no padding.

Test Plan:
All tests use CORES=4, UNITS=4, CORES_PER_BEAT=2, WORD_WIDTH=8, TUSER_WIDTH=4 (BEATS=2), with input word k = k.
1. Reorder: one beat, tuser=0xA, tlast=1, m_axis_tready=1 -> two beats:
   - Beat 0 words 0..7 = 0,1,8,9,2,3,10,11, tlast=0.
   - Beat 1 = 4,5,12,13,6,7,14,15, tlast=1.
   - tuser=0xA on both beats.
   - First beat appears 1 cycle after the input accept.
2. Back-to-back: 3 beats offered continuously, m_axis_tready=1 -> 6 output beats on consecutive cycles. s_axis_tready high only on the cycles when cnt==1 (after the first load).
3. Backpressure: drop m_axis_tready for 5 cycles mid-beat -> m_axis_tdata, cnt and tvalid are frozen, s_axis_tready=0. Output resumes with the correct second slice.
4. tlast=0 input -> m_axis_tlast=0 on both slices.
5. Reset mid-serialization: assert areset after slice 0 is accepted -> outputs go to 0 asynchronously. After release, a new beat serializes from slice 0 and the old slice 1 never appears.
6. Random valid/ready, 1000 beats, scoreboard vs reorder model -> zero mismatches, no lost or duplicated beats.
